// File: rtl/trb_readout.sv
// Trace buffer read side: after a capture, streams a status header followed by
// every BRAM entry, oldest first, over a valid/ready link.
module trb_readout #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int STAT_W = 1 + $clog2(WIDTH) + $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [STAT_W-1:0] status_i,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [WIDTH-1:0]  rd_data_i,
  output logic [WIDTH-1:0]  data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              last_o,
  output logic              busy_o,
  output logic              done_o
);

  // Stream handshake: a word transfers on a cycle with valid_o && ready_i;
  // while valid_o is high and ready_i low, data_o/last_o/valid_o hold.

  typedef enum logic [1:0] {S_IDLE, S_HEADER, S_READ, S_FLUSH} state_t;

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   LAST_C  = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0]   ONE_C   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_issued;
  logic              r_inflight;
  logic              r_inflight_last;
  logic              r_busy;
  logic              r_done;
  logic [1:0]        r_cnt;
  logic [WIDTH-1:0]  r_d0;
  logic [WIDTH-1:0]  r_d1;
  logic              r_l0;
  logic              r_l1;

  logic              w_start;
  logic              w_pop;
  logic              w_push;
  logic              w_room;
  logic              w_issue;
  logic              w_issue_last;
  logic [ADDR_W-1:0] w_issue_addr;
  logic [2:0]        w_occ;
  logic [WIDTH-1:0]  w_in_d;
  logic              w_in_l;
  logic              w_flush_done;

  assign w_start = (r_state == S_IDLE) && start_i && !abort_i;
  assign w_pop   = (r_cnt != 2'd0) && ready_i;
  // Words queued or in flight, with this cycle's pop already returning a slot.
  assign w_occ   = {1'b0, r_cnt} + {2'b00, r_inflight};
  assign w_room  = w_occ < (3'd2 + {2'b00, w_pop});

  // The oldest entry is read in the start cycle itself so data follows the header back-to-back.
  assign w_issue = w_start ||
                   (!abort_i && (r_state == S_HEADER || r_state == S_READ) &&
                    (r_issued < DEPTH_C) && w_room);
  assign w_issue_addr = w_start ? (status_i[ADDR_W-1:0] + ONE_A) : r_rd_ptr;
  assign w_issue_last = !w_start && (r_issued == LAST_C);

  assign w_push = w_start || r_inflight;
  assign w_in_d = w_start ? {{(WIDTH-STAT_W){1'b0}}, status_i} : rd_data_i;
  assign w_in_l = !w_start && r_inflight_last;

  assign w_flush_done = (r_state == S_FLUSH) && !r_inflight &&
                        ((r_cnt == 2'd0) || (r_cnt == 2'd1 && w_pop));

  assign rd_en_o   = w_issue;
  assign rd_addr_o = w_issue ? w_issue_addr : '0;
  assign data_o    = r_d0;
  assign last_o    = r_l0;
  assign valid_o   = (r_cnt != 2'd0);
  assign busy_o    = r_busy;
  assign done_o    = r_done;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state         <= S_IDLE;
      r_rd_ptr        <= '0;
      r_issued        <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
    end else begin
      r_done          <= 1'b0;
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue && w_issue_last;
      if (w_issue) begin
        r_rd_ptr <= w_issue_addr + ONE_A;
        r_issued <= w_start ? ONE_C : (r_issued + ONE_C);
      end
      if (abort_i) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_start) begin
              r_state <= S_HEADER;
              r_busy  <= 1'b1;
            end
          end
          S_HEADER: r_state <= S_READ;
          S_READ: begin
            if (r_issued == DEPTH_C) r_state <= S_FLUSH;
          end
          default: begin
            if (w_flush_done) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        endcase
      end
    end
  end

  // Two-entry first-word-fall-through queue; slot 0 is always the head.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= 2'd0;
      r_d0  <= '0;
      r_d1  <= '0;
      r_l0  <= 1'b0;
      r_l1  <= 1'b0;
    end else if (abort_i) begin
      r_cnt <= 2'd0;
      r_l0  <= 1'b0;
      r_l1  <= 1'b0;
    end else begin
      case (r_cnt)
        2'd0: begin
          if (w_push) begin
            r_d0  <= w_in_d;
            r_l0  <= w_in_l;
            r_cnt <= 2'd1;
          end
        end
        2'd1: begin
          if (w_pop && w_push) begin
            r_d0 <= w_in_d;
            r_l0 <= w_in_l;
          end else if (w_pop) begin
            r_l0  <= 1'b0;
            r_cnt <= 2'd0;
          end else if (w_push) begin
            r_d1  <= w_in_d;
            r_l1  <= w_in_l;
            r_cnt <= 2'd2;
          end
        end
        default: begin
          if (w_pop) begin
            r_d0 <= r_d1;
            r_l0 <= r_l1;
            if (w_push) begin
              r_d1 <= w_in_d;
              r_l1 <= w_in_l;
            end else begin
              r_cnt <= 2'd1;
            end
          end
        end
      endcase
    end
  end

  ovf_chk: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(!abort_i && w_push && !w_pop && r_cnt == 2'd2));

endmodule

// File: tb/tb_trb_readout.sv
// Bench for trb_readout: table of full dumps under different ready patterns,
// plus hand-written abort and mid-dump reset sequences.
module tb_trb_readout;
  localparam int WIDTH  = 32;
  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;
  localparam int STAT_W = 11;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b1;
  logic              start_i = 1'b0;
  logic              abort_i = 1'b0;
  logic [STAT_W-1:0] status_i = '0;
  logic              rd_en_o;
  logic [ADDR_W-1:0] rd_addr_o;
  logic [WIDTH-1:0]  rd_data_i = '0;
  logic [WIDTH-1:0]  data_o;
  logic              valid_o;
  logic              ready_i = 1'b0;
  logic              last_o;
  logic              busy_o;
  logic              done_o;

  trb_readout #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
    .status_i(status_i), .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o),
    .rd_data_i(rd_data_i), .data_o(data_o), .valid_o(valid_o),
    .ready_i(ready_i), .last_o(last_o), .busy_o(busy_o), .done_o(done_o)
  );

  // clock
  always #5 clk_i = ~clk_i;

  // BRAM model: one-cycle read latency
  logic [WIDTH-1:0] mem [DEPTH];
  always @(posedge clk_i) if (rd_en_o) rd_data_i <= mem[rd_addr_o];

  typedef struct {
    logic [STAT_W-1:0] status;
    logic [31:0]       base;
    int                mode;      // 0 ready high, 1 LFSR ready, 2 ready low for 20 cycles
    logic [31:0]       exp_hdr;
    logic [31:0]       exp_first;
    logic [31:0]       exp_last;
    int                exp_done;  // 0 = latency not checked
  } vec_t;
  vec_t vecs [4];

  // scoreboard
  int             checks = 0;
  int             errors = 0;
  logic [WIDTH:0] exp_q[$];
  bit             mon_en = 1'b0;
  int             cyc = 0;
  int             start_cyc = 0;
  int             acc_cnt, iss_cnt, done_seen, done_cyc, last_cnt;
  logic [31:0]    first_data, last_data;
  bit             prev_stall, prev_abort;
  logic [WIDTH:0] prev_word;
  logic [15:0]    lfsr = 16'hACE1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: sample outputs at the falling edge, return 1 time unit after the rising edge.
  task automatic step();
    logic [WIDTH:0] e;
    int occ;
    @(negedge clk_i);
    if (rst_ni && mon_en) begin
      if (prev_stall && !prev_abort) begin
        chk("hold_valid", 64'(valid_o), 64'd1);
        chk("hold_word", 64'({last_o, data_o}), 64'(prev_word));
      end
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_word: got %0h expected no word", data_o);
        end else begin
          e = exp_q.pop_front();
          chk("stream_word", 64'({last_o, data_o}), 64'(e));
        end
        if (acc_cnt == 1) first_data = data_o;
        if (last_o) begin
          last_cnt++;
          last_data = data_o;
        end
        acc_cnt++;
      end
      if (rd_en_o) begin
        iss_cnt++;
        occ = 1 + iss_cnt - acc_cnt;
        chk("outstanding_le2", 64'(occ <= 2), 64'd1);
      end
      if (done_o) begin
        done_seen++;
        done_cyc = cyc - start_cyc;
      end
      prev_stall = valid_o && !ready_i;
      prev_abort = abort_i;
      prev_word  = {last_o, data_o};
    end else begin
      prev_stall = 1'b0;
    end
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic prep(input logic [STAT_W-1:0] st, input logic [31:0] base, input logic [31:0] hdr);
    int ea;
    ea = int'(st[ADDR_W-1:0]);
    for (int i = 0; i < DEPTH; i++) mem[i] = base + 32'(i);
    exp_q.delete();
    exp_q.push_back({1'b0, hdr});
    for (int k = 0; k < DEPTH; k++)
      exp_q.push_back({(k == DEPTH - 1), base + 32'((ea + 1 + k) % DEPTH)});
    acc_cnt = 0; iss_cnt = 0; done_seen = 0; done_cyc = 0; last_cnt = 0;
    first_data = '0; last_data = '0; prev_stall = 1'b0; prev_abort = 1'b0;
  endtask

  task automatic run_dump(input vec_t v);
    prep(v.status, v.base, v.exp_hdr);
    status_i  = v.status;
    start_i   = 1'b1;
    ready_i   = (v.mode == 0) ? 1'b1 : ((v.mode == 1) ? lfsr[0] : 1'b0);
    start_cyc = cyc;
    mon_en    = 1'b1;
    step();
    for (int off = 1; off < 400 && done_seen == 0; off++) begin
      start_i = 1'b0;
      case (v.mode)
        0: ready_i = 1'b1;
        1: begin
          lfsr    = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
          ready_i = lfsr[0];
        end
        default: begin
          if (off == 20) begin
            chk("stall_reads", 64'(iss_cnt), 64'd1);
            chk("stall_valid", 64'(valid_o), 64'd1);
            chk("stall_head_is_hdr", 64'(data_o), 64'(v.exp_hdr));
          end
          ready_i = (off >= 20);
        end
      endcase
      step();
    end
    chk("done_count", 64'(done_seen), 64'd1);
    chk("word_count", 64'(acc_cnt), 64'(DEPTH + 1));
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    chk("first_data", 64'(first_data), 64'(v.exp_first));
    chk("last_data", 64'(last_data), 64'(v.exp_last));
    chk("last_flag_count", 64'(last_cnt), 64'd1);
    if (v.exp_done != 0) chk("done_cycle", 64'(done_cyc), 64'(v.exp_done));
    chk("busy_after", 64'(busy_o), 64'd0);
    chk("done_width", 64'(done_o), 64'd0);
    mon_en = 1'b0;
  endtask

  initial begin
    vecs[0] = '{status: 11'h4E4, base: 32'h0,         mode: 0, exp_hdr: 32'h0000_04E4,
                exp_first: 32'd5,         exp_last: 32'd4,         exp_done: 34};
    vecs[1] = '{status: 11'h41F, base: 32'hA000_0000, mode: 0, exp_hdr: 32'h0000_041F,
                exp_first: 32'hA000_0000, exp_last: 32'hA000_001F, exp_done: 34};
    vecs[2] = '{status: 11'h4E4, base: 32'h0,         mode: 1, exp_hdr: 32'h0000_04E4,
                exp_first: 32'd5,         exp_last: 32'd4,         exp_done: 0};
    vecs[3] = '{status: 11'h071, base: 32'h100,       mode: 2, exp_hdr: 32'h0000_0071,
                exp_first: 32'h112,       exp_last: 32'h111,       exp_done: 0};

    // reset
    #2 rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("reset_ctrl", 64'({valid_o, busy_o, rd_en_o, done_o, last_o}), 64'd0);
    chk("reset_data", 64'(data_o), 64'd0);
    chk("reset_addr", 64'(rd_addr_o), 64'd0);
    rst_ni = 1'b1;
    step();
    chk("idle_valid", 64'(valid_o), 64'd0);

    for (int i = 0; i < 4; i++) run_dump(vecs[i]);

    // abort while the 10th data word is at the head, with a start during busy beforehand
    prep(11'h4E4, 32'h0, 32'h0000_04E4);
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'(i);
    status_i  = 11'h4E4;
    start_i   = 1'b1;
    ready_i   = 1'b1;
    start_cyc = cyc;
    mon_en    = 1'b1;
    step();
    for (int off = 1; off <= 11; off++) begin
      start_i = (off == 5);
      abort_i = (off == 11);
      ready_i = (off != 11);
      if (off == 11) chk("abort_head_word", 64'(data_o), 64'd14);
      step();
    end
    abort_i = 1'b0;
    ready_i = 1'b1;
    #1;
    chk("abort_valid", 64'(valid_o), 64'd0);
    chk("abort_busy", 64'(busy_o), 64'd0);
    chk("abort_rd_en", 64'(rd_en_o), 64'd0);
    chk("abort_words", 64'(acc_cnt), 64'd10);
    repeat (5) step();
    chk("abort_no_done", 64'(done_seen), 64'd0);
    chk("abort_quiet", 64'({valid_o, busy_o}), 64'd0);
    mon_en = 1'b0;
    run_dump(vecs[0]);

    // reset in the middle of READ
    prep(11'h4E4, 32'h0, 32'h0000_04E4);
    status_i  = 11'h4E4;
    start_i   = 1'b1;
    ready_i   = 1'b1;
    start_cyc = cyc;
    mon_en    = 1'b1;
    step();
    for (int off = 1; off <= 8; off++) begin
      start_i = 1'b0;
      step();
    end
    chk("pre_rst_busy", 64'(busy_o), 64'd1);
    #2 rst_ni = 1'b0;
    #1;
    chk("rst_ctrl", 64'({valid_o, busy_o, rd_en_o, done_o, last_o}), 64'd0);
    chk("rst_data", 64'(data_o), 64'd0);
    chk("rst_addr", 64'(rd_addr_o), 64'd0);
    mon_en = 1'b0;
    step();
    step();
    rst_ni = 1'b1;
    step();
    run_dump(vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
